// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch PC generator and its BTB.
//   pc_sel_t    : next-PC source select driven from EX
//   btb_entry_t : BTB entry layout at the default geometry (32-bit, 16 entries)
//   ctr_inc/dec : 2-bit saturating counter helpers
package pc_pkg;

  typedef enum logic [1:0] {
    PC_IF  = 2'd0,
    PC_EX  = 2'd1,
    PC_REG = 2'd2
  } pc_sel_t;

  localparam int XLEN_DEF        = 32;
  localparam int BTB_ENTRIES_DEF = 16;
  localparam int IW_DEF          = $clog2(BTB_ENTRIES_DEF);
  localparam int TAG_W_DEF       = XLEN_DEF - 2 - IW_DEF;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
    logic [XLEN_DEF-1:0]  target;
    logic [1:0]           ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Ports:
//   clk, rst_n              clock / async active-low reset (clears valid bits only)
//   lookup_pc               current fetch PC
//   pred_taken, pred_target combinational prediction for lookup_pc
//   upd_valid/pc/target/taken  training strobe from EX
// Lookup reads the pre-update array, so a same-cycle update to the looked-up
// index is only visible from the next cycle on.
module pc_btb
  import pc_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken
);

  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = XLEN - 2 - IW;

  typedef struct packed {
    logic [TW-1:0]   tag;
    logic [XLEN-1:0] target;
    logic [1:0]      ctr;
  } data_t;

  logic [BTB_ENTRIES-1:0] valid;
  data_t                  mem [BTB_ENTRIES];

  // lookup
  logic [IW-1:0] l_idx;
  logic [TW-1:0] l_tag;
  data_t         l_ent;

  assign l_idx       = lookup_pc[2 +: IW];
  assign l_tag       = lookup_pc[XLEN-1 : 2+IW];
  assign l_ent       = mem[l_idx];
  assign pred_taken  = valid[l_idx] & (l_ent.tag == l_tag) & l_ent.ctr[1];
  assign pred_target = l_ent.target;

  // update
  logic [IW-1:0] u_idx;
  logic [TW-1:0] u_tag;
  data_t         u_ent;
  logic          u_hit;

  assign u_idx = upd_pc[2 +: IW];
  assign u_tag = upd_pc[XLEN-1 : 2+IW];
  assign u_ent = mem[u_idx];
  assign u_hit = valid[u_idx] & (u_ent.tag == u_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      valid        <= '0;
    else if (upd_valid && upd_taken) valid[u_idx] <= 1'b1;
  end

  // Payload is not reset; the rst_n gate just keeps updates presented while
  // reset is held from touching the array.
  always_ff @(posedge clk) begin
    if (upd_valid && rst_n) begin
      if (upd_taken) begin
        if (u_hit) mem[u_idx] <= '{tag: u_tag, target: upd_target, ctr: ctr_inc(u_ent.ctr)};
        else       mem[u_idx] <= '{tag: u_tag, target: upd_target, ctr: 2'b10};
      end else if (u_hit) begin
        mem[u_idx].ctr <= ctr_dec(u_ent.ctr);
      end
    end
  end

  // byte-offset bits never participate in indexing or tagging
  logic unused_offset;
  assign unused_offset = ^{lookup_pc[1:0], upd_pc[1:0]};

endmodule

// File: rtl/pc_gen_btb.sv
// Fetch-stage PC generator with BTB-based taken-branch prediction.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   en                         1 = advance, 0 = hold (redirects still apply)
//   PCMux                      pc_sel_t; 2'b11 behaves as PC_IF
//   PC_Execute, Imm, Reg1      EX-stage redirect operands
//   upd_*                      BTB training from EX
//   PCOut                      current fetch PC
//   pred_taken, pred_target    combinational BTB prediction for PCOut
// Next-PC priority: EX redirect > REG redirect > stall > prediction > sequential.
module pc_gen_btb
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BTB_ENTRIES  = 16,
  parameter int              INST_BYTES   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      PCMux,
  input  logic [XLEN-1:0] PC_Execute,
  input  logic [XLEN-1:0] Imm,
  input  logic [XLEN-1:0] Reg1,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic [XLEN-1:0] PCOut,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  logic [XLEN-1:0] pc, pc_nxt;

  pc_btb #(.XLEN(XLEN), .BTB_ENTRIES(BTB_ENTRIES)) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_pc  (pc),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken)
  );

  always_comb begin
    pc_nxt = pc + XLEN'(INST_BYTES);
    if (PCMux == PC_EX)       pc_nxt = PC_Execute + Imm;
    else if (PCMux == PC_REG) pc_nxt = (Reg1 + Imm) & ~XLEN'(1);
    else if (!en)             pc_nxt = pc;
    else if (pred_taken)      pc_nxt = pred_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_VECTOR;
    else        pc <= pc_nxt;
  end

  assign PCOut = pc;

endmodule

// File: tb/tb_pc_gen_btb.sv
module tb_pc_gen_btb;
  import pc_pkg::*;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam logic [31:0] RV = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  PCMux;
  logic [31:0] PC_Execute, Imm, Reg1;
  logic        upd_valid, upd_taken;
  logic [31:0] upd_pc, upd_target;
  logic [31:0] PCOut, pred_target;
  logic        pred_taken;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  pc_gen_btb #(.XLEN(32), .RESET_VECTOR(RV), .BTB_ENTRIES(N), .INST_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .PCMux(PCMux),
    .PC_Execute(PC_Execute), .Imm(Imm), .Reg1(Reg1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .PCOut(PCOut), .pred_taken(pred_taken), .pred_target(pred_target)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit [31:0] m_pc;
  bit        m_v   [N];
  bit [31:0] m_tag [N];
  bit [31:0] m_tgt [N];
  int        m_ctr [N];

  function automatic int idx_of(bit [31:0] a);
    return int'((a >> 2) % N);
  endfunction

  function automatic bit m_pred(bit [31:0] a);
    int i = idx_of(a);
    return m_v[i] && (m_tag[i] == (a >> (2 + IW))) && (m_ctr[i] >= 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = RV;
      for (int i = 0; i < N; i++) m_v[i] = 0;
    end else begin
      bit [31:0] nxt;
      int  ui;
      bit  hit;
      if (PCMux == 2'd1)      nxt = PC_Execute + Imm;
      else if (PCMux == 2'd2) nxt = (Reg1 + Imm) & 32'hFFFF_FFFE;
      else if (!en)           nxt = m_pc;
      else if (m_pred(m_pc))  nxt = m_tgt[idx_of(m_pc)];
      else                    nxt = m_pc + 4;
      if (upd_valid) begin
        ui  = idx_of(upd_pc);
        hit = m_v[ui] && (m_tag[ui] == (upd_pc >> (2 + IW)));
        if (upd_taken) begin
          if (hit) m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
          else begin
            m_v[ui]   = 1;
            m_tag[ui] = upd_pc >> (2 + IW);
            m_ctr[ui] = 2;
          end
          m_tgt[ui] = upd_target;
        end else if (hit) begin
          m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
        end
      end
      m_pc = nxt;
    end
  end

  // every-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      bit ep;
      ep = m_pred(m_pc);
      checks++;
      if (PCOut !== m_pc) begin
        failures++;
        $display("FAIL model_pc t=%0t actual=%h required=%h", $time, PCOut, m_pc);
      end
      checks++;
      if (pred_taken !== ep) begin
        failures++;
        $display("FAIL model_pred t=%0t actual=%b required=%b", $time, pred_taken, ep);
      end
      if (ep) begin
        checks++;
        if (pred_target !== m_tgt[idx_of(m_pc)]) begin
          failures++;
          $display("FAIL model_tgt t=%0t actual=%h required=%h", $time, pred_target,
                   m_tgt[idx_of(m_pc)]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic upd(input logic [31:0] p, input logic [31:0] t, input logic tk);
    upd_valid = 1; upd_pc = p; upd_target = t; upd_taken = tk;
  endtask

  initial begin
    rst_n = 1; en = 0; PCMux = PC_IF; PC_Execute = 0; Imm = 0; Reg1 = 0;
    upd_valid = 0; upd_pc = 0; upd_target = 0; upd_taken = 0;
    #2 rst_n = 0;
    cyc(); cyc();
    chk_en = 1;
    lit("reset_pc", PCOut, 32'h100);
    lit("reset_pred", {31'b0, pred_taken}, 32'h0);

    // sequential fetch
    en = 1; rst_n = 1;
    cyc(); lit("seq1", PCOut, 32'h104);
    cyc(); lit("seq2", PCOut, 32'h108);
    cyc(); lit("seq3", PCOut, 32'h10C);

    // stall, then redirects that override the stall
    en = 0;
    cyc(); lit("stall1", PCOut, 32'h10C);
    cyc(); lit("stall2", PCOut, 32'h10C);
    PCMux = PC_EX; PC_Execute = 32'h200; Imm = 32'h40;
    cyc(); lit("ex_over_stall", PCOut, 32'h240);
    PCMux = PC_REG; Reg1 = 32'h301; Imm = 32'h4;
    cyc(); lit("reg_lsb_clear", PCOut, 32'h304);
    Reg1 = 32'hFFFF_FFFC; Imm = 32'h8;
    cyc(); lit("reg_wrap", PCOut, 32'h4);

    // PCMux 2'b11 is treated as PC_IF (held, since en=0)
    PCMux = 2'b11;
    cyc(); lit("mux3_as_if", PCOut, 32'h4);

    // redirect and training in the same cycle
    PCMux = PC_EX; PC_Execute = 32'h100; Imm = 0; upd(32'h108, 32'h400, 1);
    cyc(); lit("redir_with_upd", PCOut, 32'h100);
    upd_valid = 0; PCMux = PC_IF; en = 1;
    cyc(); lit("pre_pred", PCOut, 32'h104);
    cyc(); lit("pred_pc", PCOut, 32'h108);
    lit("pred_taken", {31'b0, pred_taken}, 32'h1);
    lit("pred_target", pred_target, 32'h400);
    cyc(); lit("follow_pred", PCOut, 32'h400);

    // two not-taken updates weaken the counter below the taken threshold
    en = 0; upd(32'h108, 32'h400, 0);
    cyc(); cyc();
    upd_valid = 0; PCMux = PC_EX; PC_Execute = 32'h108;
    cyc(); lit("weak_pc", PCOut, 32'h108);
    lit("weak_pred", {31'b0, pred_taken}, 32'h0);
    PCMux = PC_IF; en = 1;
    cyc(); lit("weak_seq", PCOut, 32'h10C);

    // aliasing: 0x148 shares the index of 0x108 and evicts it
    en = 0; upd(32'h108, 32'h400, 1);
    cyc(); upd(32'h148, 32'h500, 1);
    cyc(); upd_valid = 0; PCMux = PC_EX; PC_Execute = 32'h108;
    cyc(); lit("alias_miss", {31'b0, pred_taken}, 32'h0);
    PC_Execute = 32'h148;
    cyc(); lit("alias_new_pred", {31'b0, pred_taken}, 32'h1);
    lit("alias_new_tgt", pred_target, 32'h500);

    // lookup and update of the same index in one cycle: old target used
    PCMux = PC_IF; en = 1; upd(32'h148, 32'h600, 1);
    cyc(); lit("rbw_old_target", PCOut, 32'h500);
    upd_valid = 0; en = 0; PCMux = PC_EX; PC_Execute = 32'h148;
    cyc(); lit("rbw_new_target", pred_target, 32'h600);

    // asynchronous reset mid-stream with an update pending
    PCMux = PC_IF; en = 1; upd(32'h148, 32'h700, 1);
    rst_n = 0;
    #1;
    lit("async_rst_pc", PCOut, 32'h100);
    lit("async_rst_pred", {31'b0, pred_taken}, 32'h0);
    cyc(); cyc();
    lit("rst_hold_pc", PCOut, 32'h100);
    upd_valid = 0; rst_n = 1;
    cyc(); lit("post_rst_seq", PCOut, 32'h104);
    PCMux = PC_EX; PC_Execute = 32'h148; Imm = 0;
    cyc(); lit("btb_cleared", {31'b0, pred_taken}, 32'h0);
    PCMux = PC_IF;
    cyc(); lit("btb_cleared_seq", PCOut, 32'h14C);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
